// File: rtl/evo_bsp_pkg.sv
// Board-support constants and types shared by the PCC transmit path.
package evo_bsp_pkg;

  localparam int unsigned PCC_DWIDTH         = 14;
  localparam int unsigned PCC_MAX_BURST_SIZE = 1024;
  localparam int unsigned PCC_MAX_NUM_BURST  = 512;

  localparam int unsigned PCC_TX_FIFO_DEPTH = 16;
  localparam int unsigned PCC_TX_CLK_DIV    = 2;
  localparam int unsigned PCC_TX_GAP_CYCLES = 4;

  typedef logic [$clog2(PCC_MAX_BURST_SIZE+1)-1:0] evo_pcc_flit_cnt_t;
  typedef logic [$clog2(PCC_MAX_NUM_BURST+1)-1:0]  evo_pcc_burst_cnt_t;

  typedef struct packed {
    logic                  clk;
    logic                  den1;
    logic                  den2;
    logic [PCC_DWIDTH-1:0] data;
  } evo_pcc_t;

  // One-hot transmit FSM state; exactly one field set at a time.
  typedef struct packed {
    logic done;
    logic gap;
    logic high;
    logic low;
    logic wait_;
    logic idle;
  } evo_pcc_tx_st_t;

  localparam evo_pcc_tx_st_t PccTxStIdle = 6'b000001;
  localparam evo_pcc_tx_st_t PccTxStWait = 6'b000010;
  localparam evo_pcc_tx_st_t PccTxStLow  = 6'b000100;
  localparam evo_pcc_tx_st_t PccTxStHigh = 6'b001000;
  localparam evo_pcc_tx_st_t PccTxStGap  = 6'b010000;
  localparam evo_pcc_tx_st_t PccTxStDone = 6'b100000;

  // Width of a counter that must reach the larger of two cycle counts.
  function automatic int unsigned phase_cnt_width(int unsigned a, int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/evo_pcc_burst_tx_if.sv
// Control, write-stream and PCC pin bundle of the burst transmit engine.
interface evo_pcc_burst_tx_if #(
  parameter int unsigned DWIDTH = evo_bsp_pkg::PCC_DWIDTH,
  parameter int unsigned FW     = $clog2(evo_bsp_pkg::PCC_MAX_BURST_SIZE + 1),
  parameter int unsigned BW     = $clog2(evo_bsp_pkg::PCC_MAX_NUM_BURST + 1)
);
  logic [FW-1:0]     cfg_burst_size;
  logic [BW-1:0]     cfg_num_burst;
  logic              cfg_den_en;
  logic              start;
  logic              abort;
  logic              wr_valid;
  logic              wr_ready;
  logic [DWIDTH-1:0] wr_data;
  logic              pcc_clk;
  logic              pcc_den1;
  logic              pcc_den2;
  logic [DWIDTH-1:0] pcc_data;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              cfg_err;

  modport master (
    output cfg_burst_size, cfg_num_burst, cfg_den_en, start, abort, wr_valid, wr_data,
    input  wr_ready, pcc_clk, pcc_den1, pcc_den2, pcc_data, busy, done, underrun, cfg_err
  );

  modport slave (
    input  cfg_burst_size, cfg_num_burst, cfg_den_en, start, abort, wr_valid, wr_data,
    output wr_ready, pcc_clk, pcc_den1, pcc_den2, pcc_data, busy, done, underrun, cfg_err
  );
endinterface

// File: rtl/evo_pcc_tx_fifo.sv
// Synchronous FIFO with flush; pointers wrap naturally since DEPTH is a power of two.
module evo_pcc_tx_fifo #(
  parameter int unsigned DWIDTH = 14,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DWIDTH-1:0]          wr_data_i,
  output logic [DWIDTH-1:0]          rd_data_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign do_push   = push_i & ~full_o & ~flush_i;
  assign do_pop    = pop_i & (count_q != '0) & ~flush_i;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/evo_pcc_burst_tx.sv
// PCC burst transmitter: buffers words, then clocks them out in framed bursts with gaps.
module evo_pcc_burst_tx
  import evo_bsp_pkg::*;
#(
  parameter int unsigned DWIDTH         = PCC_DWIDTH,
  parameter int unsigned FIFO_DEPTH     = PCC_TX_FIFO_DEPTH,
  parameter int unsigned MAX_BURST_SIZE = PCC_MAX_BURST_SIZE,
  parameter int unsigned MAX_NUM_BURST  = PCC_MAX_NUM_BURST,
  parameter int unsigned CLK_DIV        = PCC_TX_CLK_DIV,
  parameter int unsigned GAP_CYCLES     = PCC_TX_GAP_CYCLES
) (
  input logic               clk,
  input logic               reset,
  evo_pcc_burst_tx_if.slave bus
);
  localparam int unsigned FW = $clog2(MAX_BURST_SIZE + 1);
  localparam int unsigned BW = $clog2(MAX_NUM_BURST + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = phase_cnt_width(CLK_DIV, GAP_CYCLES);

  evo_pcc_tx_st_t    st_q, st_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [FW-1:0]     flit_q, flit_d, size_q, size_d;
  logic [BW-1:0]     burst_q, burst_d, num_q, num_d;
  logic              den_en_q, den_en_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              underrun_q, underrun_d, cfg_err_q, cfg_err_d;

  logic              fifo_pop, fifo_flush, fifo_full;
  logic [DWIDTH-1:0] fifo_rd_data;
  logic [CW-1:0]     fifo_count;

  evo_pcc_tx_fifo #(
    .DWIDTH(DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (fifo_flush),
    .push_i   (bus.wr_valid),
    .pop_i    (fifo_pop),
    .wr_data_i(bus.wr_data),
    .rd_data_o(fifo_rd_data),
    .full_o   (fifo_full),
    .count_o  (fifo_count)
  );

  always_comb begin
    st_d       = st_q;
    ph_d       = ph_q;
    flit_d     = flit_q;
    burst_d    = burst_q;
    size_d     = size_q;
    num_d      = num_q;
    den_en_d   = den_en_q;
    data_d     = data_q;
    underrun_d = underrun_q;
    cfg_err_d  = cfg_err_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (1'b1)
      st_q.idle: begin
        if (bus.start) begin
          underrun_d = 1'b0;
          if (bus.cfg_burst_size == '0 || bus.cfg_num_burst == '0) begin
            cfg_err_d = 1'b1;
            st_d      = PccTxStDone;
          end else begin
            cfg_err_d = 1'b0;
            size_d    = bus.cfg_burst_size;
            num_d     = bus.cfg_num_burst;
            den_en_d  = bus.cfg_den_en;
            flit_d    = '0;
            burst_d   = '0;
            st_d      = PccTxStWait;
          end
        end
      end
      st_q.wait_: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rd_data;
          ph_d     = '0;
          st_d     = PccTxStLow;
        end else if (flit_q != '0) begin
          underrun_d = 1'b1;
        end
      end
      st_q.low: begin
        if (ph_q == PW'(CLK_DIV - 1)) begin
          ph_d = '0;
          st_d = PccTxStHigh;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      st_q.high: begin
        if (ph_q == PW'(CLK_DIV - 1)) begin
          ph_d   = '0;
          flit_d = flit_q + FW'(1);
          if (flit_q + FW'(1) != size_q) begin
            st_d = PccTxStWait;
          end else if (burst_q + BW'(1) == num_q) begin
            st_d = PccTxStDone;
          end else begin
            burst_d = burst_q + BW'(1);
            flit_d  = '0;
            st_d    = PccTxStGap;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      st_q.gap: begin
        if (ph_q == PW'(GAP_CYCLES - 1)) begin
          ph_d = '0;
          st_d = PccTxStWait;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      st_q.done: st_d = PccTxStIdle;
      default:   st_d = PccTxStIdle;
    endcase
    // Abort overrides everything, including a same-cycle start.
    if (bus.abort) begin
      st_d       = PccTxStIdle;
      ph_d       = '0;
      data_d     = data_q;
      underrun_d = underrun_q;
      cfg_err_d  = cfg_err_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= PccTxStIdle;
      ph_q       <= '0;
      flit_q     <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      num_q      <= '0;
      den_en_q   <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      ph_q       <= ph_d;
      flit_q     <= flit_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
      num_q      <= num_d;
      den_en_q   <= den_en_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // WAIT with flit_q != 0 is a mid-burst stall, so framing stays up there.
  assign bus.pcc_den1 = den_en_q & (st_q.low | st_q.high | (st_q.wait_ & (flit_q != '0)));
  assign bus.pcc_den2 = den_en_q & (st_q.low | st_q.high | st_q.gap |
                                    (st_q.wait_ & ((flit_q != '0) | (burst_q != '0))));
  assign bus.pcc_clk  = st_q.high;
  assign bus.pcc_data = data_q;
  assign bus.busy     = st_q.wait_ | st_q.low | st_q.high | st_q.gap;
  assign bus.done     = st_q.done;
  assign bus.underrun = underrun_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.wr_ready = ~fifo_full;

endmodule

// File: tb/tb_evo_pcc_burst_tx.sv
// Directed bench for evo_pcc_burst_tx: vector table of transfers plus hand-written corner cases.
module tb_evo_pcc_burst_tx;
  localparam int DW      = 14;
  localparam int FW      = 11;
  localparam int BW      = 10;
  localparam int CLK_DIV = 2;
  localparam int GAP     = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  evo_pcc_burst_tx_if #(.DWIDTH(DW), .FW(FW), .BW(BW)) bus ();

  evo_pcc_burst_tx dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int den_en;
    int size;
    int num;
    int words;
    int exp_pulses;
    int exp_den1;
    int exp_den2;
    int exp_gaps;
    int exp_err;
    int exp_busy;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  int n_rise, n_done, n_den1, n_den2, n_gaps, hi_bad, gap_bad, hi_len, den1_low;
  int busy_seen, prev_clk, prev_den1, prev_den2;
  int got[$];
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic clr();
    n_rise = 0; n_done = 0; n_den1 = 0; n_den2 = 0; n_gaps = 0;
    hi_bad = 0; gap_bad = 0; hi_len = 0; den1_low = 0; busy_seen = 0;
    prev_clk = 0; prev_den1 = 0; prev_den2 = 0;
    got.delete();
    exp_q.delete();
  endtask

  task automatic sample();
    if (bus.busy) busy_seen = 1;
    if (bus.done) n_done++;
    if (bus.pcc_clk && prev_clk == 0) begin
      n_rise++;
      got.push_back(int'(bus.pcc_data));
    end
    if (bus.pcc_clk) hi_len++;
    else begin
      if (prev_clk != 0 && hi_len != CLK_DIV) hi_bad++;
      hi_len = 0;
    end
    if (bus.pcc_den2 && prev_den2 == 0) n_den2++;
    if (bus.pcc_den1 && prev_den1 == 0) begin
      n_den1++;
      // Between bursts den1 is low for the gap plus the one cycle that fetches the next word.
      if (prev_den2 != 0 && den1_low > 0) begin
        n_gaps++;
        if (den1_low != GAP + 1) gap_bad++;
      end
    end
    if (bus.pcc_den2 && !bus.pcc_den1) den1_low++;
    else den1_low = 0;
    prev_clk  = int'(bus.pcc_clk);
    prev_den1 = int'(bus.pcc_den1);
    prev_den2 = int'(bus.pcc_den2);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input int v);
    bus.wr_valid = 1'b1;
    bus.wr_data  = DW'(v);
    exp_q.push_back(v);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_start(input int den_en, input int size, input int num);
    bus.cfg_den_en     = den_en[0];
    bus.cfg_burst_size = FW'(size);
    bus.cfg_num_burst  = BW'(num);
    bus.start          = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int b = 0;
    while (n_done == 0 && b < budget) begin
      tick();
      b++;
    end
    check({name, "_done_seen"}, int'(n_done != 0), 1);
    steps(3);
  endtask

  task automatic check_data(input string name);
    check({name, "_len"}, got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) check({name, "_data"}, got[k], exp_q[k]);
  endtask

  initial begin
    int cnt;
    bus.cfg_burst_size = '0;
    bus.cfg_num_burst  = '0;
    bus.cfg_den_en     = 1'b0;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.wr_valid       = 1'b0;
    bus.wr_data        = '0;
    reset              = 1'b1;
    clr();

    //         den size num words pulses den1 den2 gaps err busy
    vecs[0] = '{1, 4, 1, 4, 4, 1, 1, 0, 0, 1};
    vecs[1] = '{1, 3, 2, 6, 6, 2, 1, 1, 0, 1};
    vecs[2] = '{0, 2, 2, 4, 4, 0, 0, 0, 0, 1};
    vecs[3] = '{1, 1, 3, 3, 3, 3, 1, 2, 0, 1};
    vecs[4] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[5] = '{1, 2, 0, 0, 0, 0, 0, 0, 1, 0};

    steps(2);
    check("rst_pcc_clk", int'(bus.pcc_clk), 0);
    check("rst_den1", int'(bus.pcc_den1), 0);
    check("rst_den2", int'(bus.pcc_den2), 0);
    check("rst_data", int'(bus.pcc_data), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_underrun", int'(bus.underrun), 0);
    check("rst_cfg_err", int'(bus.cfg_err), 0);
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    reset = 1'b0;
    steps(2);

    for (int i = 0; i < 6; i++) begin
      clr();
      for (int j = 0; j < vecs[i].words; j++) push_word(i * 16 + j + 1);
      do_start(vecs[i].den_en, vecs[i].size, vecs[i].num);
      wait_done("vec", 400);
      check("vec_pulses", n_rise, vecs[i].exp_pulses);
      check("vec_den1_rises", n_den1, vecs[i].exp_den1);
      check("vec_den2_rises", n_den2, vecs[i].exp_den2);
      check("vec_gaps", n_gaps, vecs[i].exp_gaps);
      check("vec_gap_len_bad", gap_bad, 0);
      check("vec_high_len_bad", hi_bad, 0);
      check("vec_done_count", n_done, 1);
      check("vec_cfg_err", int'(bus.cfg_err), vecs[i].exp_err);
      check("vec_busy_seen", busy_seen, vecs[i].exp_busy);
      check("vec_underrun", int'(bus.underrun), 0);
      check_data("vec");
    end

    // Start-to-first-rise latency with a non-empty FIFO; a valid start also clears cfg_err.
    clr();
    push_word(16'h0abc);
    bus.cfg_den_en = 1'b1; bus.cfg_burst_size = FW'(1); bus.cfg_num_burst = BW'(1);
    bus.start = 1'b1;
    cnt = 0;
    do begin
      tick();
      bus.start = 1'b0;
      cnt++;
    end while (!bus.pcc_clk && cnt < 20);
    check("lat_first_rise", cnt, CLK_DIV + 2);
    check("lat_cfg_err_cleared", int'(bus.cfg_err), 0);
    wait_done("lat", 100);
    check_data("lat");

    // Underrun: stall low mid-burst, resume on refill, flag sticky until next start.
    clr();
    push_word(16'h30); push_word(16'h31);
    do_start(1, 4, 1);
    steps(40);
    check("ur_flag", int'(bus.underrun), 1);
    check("ur_clk_low", int'(bus.pcc_clk), 0);
    check("ur_busy", int'(bus.busy), 1);
    check("ur_den1_held", int'(bus.pcc_den1), 1);
    check("ur_pulses_stalled", n_rise, 2);
    push_word(16'h32); push_word(16'h33);
    wait_done("ur", 100);
    check("ur_pulses", n_rise, 4);
    check("ur_sticky", int'(bus.underrun), 1);
    check_data("ur");
    clr();
    push_word(16'h34);
    do_start(1, 1, 1);
    check("ur_cleared", int'(bus.underrun), 0);
    wait_done("ur2", 100);

    // A start while busy must not reprogram the transfer.
    clr();
    push_word(16'h40); push_word(16'h41);
    do_start(1, 2, 1);
    steps(3);
    do_start(1, 1, 1);
    wait_done("busy_start", 100);
    check("busy_start_pulses", n_rise, 2);
    check("busy_start_done_count", n_done, 1);

    // FIFO full, and simultaneous push+pop at 15 entries.
    clr();
    for (int j = 0; j < 15; j++) push_word(16'h100 + j);
    check("fifo_15_ready", int'(bus.wr_ready), 1);
    bus.cfg_den_en = 1'b1; bus.cfg_burst_size = FW'(1); bus.cfg_num_burst = BW'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    push_word(16'h1ff);
    check("fifo_pushpop_ready", int'(bus.wr_ready), 1);
    wait_done("fifo1", 100);
    check("fifo_still_15", int'(bus.wr_ready), 1);
    push_word(16'h1fe);
    check("fifo_full_ready", int'(bus.wr_ready), 0);
    bus.wr_valid = 1'b1; bus.wr_data = DW'(16'h1fd);
    tick();
    bus.wr_valid = 1'b0;
    n_done = 0;
    do_start(1, 16, 1);
    wait_done("fifo2", 400);
    check("fifo_drain_pulses", n_rise, 17);
    check_data("fifo");

    // Abort during the second HIGH phase.
    clr();
    for (int j = 0; j < 4; j++) push_word(16'h20 + j);
    do_start(1, 4, 1);
    cnt = 0;
    while (n_rise < 2 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("abort_in_high", int'(bus.pcc_clk), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_clk", int'(bus.pcc_clk), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_den2", int'(bus.pcc_den2), 0);
    steps(10);
    check("abort_no_done", n_done, 0);
    clr();
    do_start(1, 1, 1);
    steps(20);
    check("abort_fifo_empty", n_rise, 0);
    check("abort_restart_busy", int'(bus.busy), 1);
    push_word(16'h55);
    wait_done("abort", 100);
    check_data("abort");

    // Asynchronous reset mid-HIGH.
    clr();
    push_word(16'h66); push_word(16'h67);
    do_start(1, 2, 1);
    cnt = 0;
    while (!bus.pcc_clk && cnt < 40) begin
      tick();
      cnt++;
    end
    check("rst2_in_high", int'(bus.pcc_clk), 1);
    reset = 1'b1;
    #1;
    check("rst2_pcc_clk", int'(bus.pcc_clk), 0);
    check("rst2_den1", int'(bus.pcc_den1), 0);
    check("rst2_den2", int'(bus.pcc_den2), 0);
    check("rst2_data", int'(bus.pcc_data), 0);
    check("rst2_busy", int'(bus.busy), 0);
    check("rst2_wr_ready", int'(bus.wr_ready), 1);
    steps(2);
    reset = 1'b0;
    steps(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
